// File: rtl/dm_main_mem_if.sv
// Memory port between the cache controller (initiator) and main memory (responder).
//   mem_req_valid  request present, held by the initiator until it samples mem_rsp_ready=1
//   mem_req_rw     1 = write line, 0 = read line
//   mem_req_addr   byte address, bits [3:0] ignored
//   mem_req_data   write line data
//   mem_rsp_ready  one-cycle completion pulse
//   mem_rsp_data   read line data, valid while mem_rsp_ready=1
interface dm_main_mem_if;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_rsp_ready;
  logic [127:0] mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_req_rw,
    output mem_req_addr,
    output mem_req_data,
    input  mem_rsp_ready,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_rw,
    input  mem_req_addr,
    input  mem_req_data,
    output mem_rsp_ready,
    output mem_rsp_data
  );
endinterface

// File: rtl/dm_main_mem.sv
// Behavioural main-memory responder for the dm_cache memory port. Serves one 128-bit line
// read or write at a time with a fixed access latency.
//   clk  rising-edge clock
//   rst  synchronous active-high reset (does not clear the storage array)
//   mem  dm_main_mem_if slave modport: request in, completion pulse and read data out
// Timing: request accepted at edge t0 commits at edge t0+LATENCY, ready is high for the
// single cycle after that edge, next acceptance is possible at edge t0+LATENCY+2.
module dm_main_mem #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input logic          clk,
  input logic          rst,
  dm_main_mem_if.slave mem
);

  if (LATENCY == 0 || LATENCY > 255) begin : gen_bad_latency
    $error("dm_main_mem: LATENCY must be in 1..255");
  end
  if (DEPTH_LOG2 == 0 || DEPTH_LOG2 > 27) begin : gen_bad_depth
    $error("dm_main_mem: DEPTH_LOG2 must be in 1..27");
  end

  localparam int unsigned Lines   = 1 << DEPTH_LOG2;
  localparam logic [7:0]  CntLoad = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    rw_q, rw_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [127:0]            wdata_q, wdata_d;
  logic                    rsp_ready_q, rsp_ready_d;
  logic [127:0]            rsp_data_q, rsp_data_d;
  logic                    mem_we;

  logic [127:0] mem_q [Lines];

  // Offset and alias bits above the index play no part in line selection.
  logic unused_addr;
  assign unused_addr = ^{mem.mem_req_addr[31:DEPTH_LOG2+4], mem.mem_req_addr[3:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rsp_ready_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    mem_we      = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem.mem_req_valid) begin
          rw_d    = mem.mem_req_rw;
          idx_d   = mem.mem_req_addr[DEPTH_LOG2+3:4];
          wdata_d = mem.mem_req_data;
          cnt_d   = CntLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          rsp_ready_d = 1'b1;
          state_d     = StResp;
          if (rw_q) begin
            mem_we = 1'b1;
          end else begin
            rsp_data_d = mem_q[idx_q];
          end
        end
      end
      StResp: begin
        // Initiator still holds valid for the completing request, so never accept here.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      rsp_ready_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Request latches carry no reset; they are only consumed after a fresh acceptance.
  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  // Storage is never cleared; reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign mem.mem_rsp_ready = rsp_ready_q;
  assign mem.mem_rsp_data  = rsp_data_q;

endmodule

// File: doc/dm_main_mem.md
Name: dm_main_mem

Overview:
- Behavioural main-memory responder on the far side of the cache controller's memory port. The controller is the initiator; this block is the responder.
- Services 128-bit line refills (reads) and dirty-line write-backs (writes) with a fixed, parameterised access latency.
- Used as the backing store for dm_cache simulation and FPGA bring-up. Handles one outstanding request at a time.

Parameters:
- LATENCY, 4, cycles from request acceptance to ready pulse; legal range 1..255; elaboration error if outside.
- DEPTH_LOG2, 12, log2 of line count (4096 lines x 128 bits).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- mem_req_valid  in  1  request present; initiator holds it until it samples mem_rsp_ready=1
- mem_req_rw  in  1  1=write line, 0=read line
- mem_req_addr  in  32  byte address; bits [3:0] ignored (line aligned)
- mem_req_data  in  128  write line data
- mem_rsp_ready  out  1  one-cycle completion pulse
- mem_rsp_data  out  128  read line data; valid while mem_rsp_ready=1

Behaviour:
- Line index = mem_req_addr[DEPTH_LOG2+3:4]. Upper address bits are ignored, so addresses differing only above the index alias to the same line.
- Storage is an array of 2^DEPTH_LOG2 x 128 bits. It is not cleared by rst; contents are X until written.
- FSM states:
  - IDLE: if mem_req_valid=1 at an edge, latch addr/rw/data, load cnt=LATENCY-1, go to BUSY.
  - BUSY: if cnt!=0, decrement; if cnt==0, perform access, assert mem_rsp_ready, go to RESP.
  - RESP: mem_rsp_ready=1 for this cycle only; next edge clears ready and returns to IDLE.
- Timing, with the request accepted at edge t0:
  - mem_rsp_ready rises after edge t0+LATENCY and falls after edge t0+LATENCY+1. It is exactly one cycle wide.
  - A write commits to the array at edge t0+LATENCY.
  - For a read, mem_rsp_data is registered at edge t0+LATENCY from the array contents at that edge.
- mem_rsp_data holds its last read value after ready drops. Writes do not change mem_rsp_data.
- Request inputs are sampled only in IDLE. Changes to valid/addr/data/rw during BUSY or RESP are ignored; the latched copy is used.
- No acceptance in RESP, because the initiator still holds valid for the completing request. The earliest next acceptance is edge t0+LATENCY+2, so back-to-back throughput is one request per LATENCY+2 cycles.
- Read after write to the same line returns the written data (the write committed earlier).
- cnt width is 8 bits; no wrap possible within the legal LATENCY range.
- Reset:
  - rst=1 at any edge forces state=IDLE, cnt=0, mem_rsp_ready=0, mem_rsp_data=0. rst has priority over every transition.
  - Reset in BUSY before the commit edge aborts the request: the array is unmodified and no ready pulse is issued.
  - A request with valid=1 during the rst cycle is not accepted. The first acceptance possible is the first edge with rst=0.
- Simultaneous rst=1 and commit edge: reset wins, no write.

Test Plan:
1. Write then read, LATENCY=4: write addr 0x0000_0010, data 0x0123...CDEF (128b) at edge 0. Expect ready high only in the cycle after edge 4. Read the same addr at edge 6; expect ready in the cycle after edge 10 with mem_rsp_data=0x0123...CDEF.
2. Aliasing/offset, DEPTH_LOG2=12: write 0xAA..AA to 0x0000_0020. Read 0x0001_002C (same index 2, different upper and offset bits). Expect 0xAA..AA.
3. Latency sweep, LATENCY=1 and 7: read request at edge 0. Expect ready after edge 1 and edge 7 respectively. Ready is one cycle wide; no second pulse while valid is held through RESP.
4. Input changes mid-request: issue a write to index 5 with data D1. During BUSY, change addr to index 6 and data to D2. Expect index 5 = D1 and index 6 unchanged, verified by reads.
5. Reset mid-operation: write D3 to index 9 (old value D0), assert rst at edge t0+2 with LATENCY=4. Expect no ready pulse and mem_rsp_data=0. A later read of index 9 returns D0.
6. Back-to-back: initiator drops valid the cycle after ready, then re-asserts immediately. Expect acceptances at edges 0 and 6 (LATENCY=4), ready pulses after edges 4 and 10, and no spurious acceptance in RESP.
